// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-port memory arbiter.
//            - owner_e     : which port owns the read response in flight
//            - DEF_ADDR_W  : default address width
//            - DEF_DATA_W  : default data width
//            - STALL_CNT_W : width of the fetch starvation counter
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int STALL_CNT_W = 4;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_IF   = 2'd1,
      OWNER_LS   = 2'd2
   } owner_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, synchronous-read memory between the
//            instruction-fetch port (if_*) and the load/store port (ls_*).
//            One grant per cycle; load/store wins collisions unless fetch
//            has been denied MAX_STALL cycles in a row. The read response
//            one cycle later is steered to the port that issued the read.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            if_req/if_addr         - fetch request (read only)
//            if_gnt                 - fetch accepted this cycle (comb.)
//            if_rvalid/if_rdata     - fetch read response
//            ls_req/ls_we/ls_bit_wr_en/ls_addr/ls_wr_data
//                                   - load/store request
//            ls_gnt                 - load/store accepted this cycle (comb.)
//            ls_rvalid/ls_rdata     - load read response
//            mem_en/mem_wr_en/mem_bit_wr_en/mem_addr/mem_wr_data
//                                   - memory command (mirrors granted port)
//            mem_rd_data            - memory read data (one cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_STALL = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,

   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [DATA_W-1:0] ls_bit_wr_en,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wr_data,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,

   output logic              mem_en,
   output logic              mem_wr_en,
   output logic [DATA_W-1:0] mem_bit_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data
);

   localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(MAX_STALL);
   localparam logic [STALL_CNT_W-1:0] STALL_ONE   = STALL_CNT_W'(1);

   owner_e                 owner;
   owner_e                 owner_next;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [STALL_CNT_W-1:0] stall_cnt_next;

   // ------------------------------------------------------------------------
   // Arbitration, memory command steering and next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      if_gnt         = 1'b0;
      ls_gnt         = 1'b0;
      mem_en         = 1'b0;
      mem_wr_en      = 1'b0;
      mem_bit_wr_en  = '0;
      mem_addr       = '0;
      mem_wr_data    = '0;
      owner_next     = OWNER_NONE;
      stall_cnt_next = '0;

      if (!rst) begin
         // Fetch wins when alone, or once it has waited out the stall limit.
         if (if_req && (!ls_req || (stall_cnt >= STALL_LIMIT))) begin
            if_gnt = 1'b1;
         end else if (ls_req) begin
            ls_gnt = 1'b1;
         end
      end

      if (if_gnt) begin
         mem_en     = 1'b1;
         mem_addr   = if_addr;
         owner_next = OWNER_IF;
      end else if (ls_gnt) begin
         mem_en        = 1'b1;
         mem_wr_en     = ls_we;
         mem_bit_wr_en = ls_we ? ls_bit_wr_en : '0;
         mem_addr      = ls_addr;
         mem_wr_data   = ls_wr_data;
         // Stores return nothing, so only loads claim the response slot.
         owner_next    = ls_we ? OWNER_NONE : OWNER_LS;
      end

      if (if_req && !if_gnt) begin
         stall_cnt_next = (stall_cnt >= STALL_LIMIT) ? STALL_LIMIT
                                                     : stall_cnt + STALL_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Response owner and starvation counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         owner     <= OWNER_NONE;
         stall_cnt <= '0;
      end else begin
         owner     <= owner_next;
         stall_cnt <= stall_cnt_next;
      end
   end

   // Response gating also masks with rst so a read granted just before reset
   // never surfaces while reset is asserted.
   always_comb begin
      if_rvalid = (owner == OWNER_IF) && !rst;
      ls_rvalid = (owner == OWNER_LS) && !rst;
      if_rdata  = if_rvalid ? mem_rd_data : '0;
      ls_rdata  = ls_rvalid ? mem_rd_data : '0;
   end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a write-first,
//            synchronous-read memory model. Stimulus pushes expected read
//            responses into a scoreboard queue; a monitor pops and compares
//            whenever a response valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_we;
   logic [DW-1:0] ls_bit_wr_en;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wr_data;
   logic          ls_gnt, ls_rvalid;
   logic [DW-1:0] ls_rdata;
   logic          mem_en, mem_wr_en;
   logic [DW-1:0] mem_bit_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_rd_data;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STALL(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_bit_wr_en(ls_bit_wr_en),
      .ls_addr(ls_addr), .ls_wr_data(ls_wr_data), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_bit_wr_en(mem_bit_wr_en),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          is_ls;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Memory model: command captured mid-cycle, applied on the rising edge.
   // Write-first: a write's merged word is also returned as read data.
   // ------------------------------------------------------------------------
   logic [DW-1:0] mem [0:255];
   initial begin
      logic          c_en, c_we;
      logic [DW-1:0] c_be, c_wd, w;
      logic [7:0]    c_idx;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h00] = 32'h00000013;   // 0x000
      mem[8'h01] = 32'h00100113;   // 0x004
      mem[8'h02] = 32'h00200193;   // 0x008
      mem[8'h04] = 32'h00500093;   // 0x010
      mem[8'h40] = 32'hDEADBEEF;   // 0x100
      mem[8'h80] = 32'h11112222;   // 0x200
      mem_rd_data = 32'h0;
      forever begin
         @(negedge clk);
         c_en  = mem_en;
         c_we  = mem_wr_en;
         c_be  = mem_bit_wr_en;
         c_wd  = mem_wr_data;
         c_idx = mem_addr[9:2];
         @(posedge clk);
         if (c_en) begin
            if (c_we) begin
               w = (mem[c_idx] & ~c_be) | (c_wd & c_be);
               mem[c_idx] = w;
               mem_rd_data = w;
            end else begin
               mem_rd_data = mem[c_idx];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Response monitor
   // ------------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_rvalid && ls_rvalid) begin
            checks++;
            errors++;
            $display("FAIL rvalid_exclusive: got if_rvalid=1 ls_rvalid=1 expected at most one");
         end
         if (if_rvalid || ls_rvalid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid: got if_rvalid=%0b ls_rvalid=%0b expected none",
                        if_rvalid, ls_rvalid);
            end else begin
               e = sb.pop_front();
               chk("rsp_port_is_ls", 64'(ls_rvalid), 64'(e.is_ls));
               chk("rsp_data", 64'(ls_rvalid ? ls_rdata : if_rdata), 64'(e.data));
               chk("rsp_idle_rdata", 64'(ls_rvalid ? if_rdata : ls_rdata), 64'h0);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // One bus cycle: drive, check grants mid-cycle, schedule expected response
   // push_port: 0 none, 1 fetch, 2 load/store
   // ------------------------------------------------------------------------
   task automatic cyc(input logic ireq, input logic [AW-1:0] iaddr,
                      input logic lreq, input logic lwe, input logic [DW-1:0] lbe,
                      input logic [AW-1:0] laddr, input logic [DW-1:0] lwd,
                      input logic exp_ig, input logic exp_lg,
                      input int push_port, input logic [DW-1:0] push_data,
                      input string name);
      exp_t e;
      if_req       = ireq;
      if_addr      = iaddr;
      ls_req       = lreq;
      ls_we        = lwe;
      ls_bit_wr_en = lbe;
      ls_addr      = laddr;
      ls_wr_data   = lwd;
      @(negedge clk);
      chk({name, "_gnt"}, {62'h0, if_gnt, ls_gnt}, {62'h0, exp_ig, exp_lg});
      if (push_port != 0) begin
         e.is_ls = (push_port == 2);
         e.data  = push_data;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h10;
      ls_req = 1'b1; ls_we = 1'b0; ls_bit_wr_en = '0; ls_addr = 32'h100; ls_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      // Requests present during reset must not be granted.
      @(negedge clk);
      chk("rst_ctrl", {58'h0, if_gnt, ls_gnt, mem_en, mem_wr_en, if_rvalid, ls_rvalid}, 64'h0);
      chk("rst_rdata", {if_rdata, ls_rdata}, 64'h0);
      chk("rst_mem_addr", 64'(mem_addr), 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      chk("post_rst_ctrl", {58'h0, if_gnt, ls_gnt, mem_en, mem_wr_en, if_rvalid, ls_rvalid}, 64'h0);
      chk("post_rst_rdata", {if_rdata, ls_rdata}, 64'h0);
      chk("post_rst_owner", 64'(dut.owner), 64'(OWNER_NONE));
      chk("post_rst_stall", 64'(dut.stall_cnt), 64'h0);
      @(posedge clk);
      #1;

      // Single fetch
      cyc(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00500093, "single_fetch");
      idle(1);

      // Collision: load wins, fetch follows once load drops
      cyc(1, 32'h0, 1, 0, 0, 32'h100, 0, 0, 1, 2, 32'hDEADBEEF, "collide_ls");
      cyc(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00000013, "collide_if");
      idle(1);

      // Starvation: continuous stores, fetch held
      for (int c = 0; c < 4; c++)
         cyc(1, 32'h10, 1, 1, 32'hFFFFFFFF, 32'h300 + 32'(4 * c), 32'(c), 0, 1, 0, 0, "starve_deny");
      cyc(1, 32'h10, 1, 1, 32'hFFFFFFFF, 32'h310, 32'h5, 1, 0, 1, 32'h00500093, "starve_force");
      chk("starve_stall_cleared", 64'(dut.stall_cnt), 64'h0);
      cyc(1, 32'h0, 1, 1, 32'hFFFFFFFF, 32'h310, 32'h5, 0, 1, 0, 0, "starve_ls_again");
      cyc(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00000013, "starve_if_after");
      idle(1);

      // Partial store then load of the same word (no rvalid for the store)
      cyc(0, 0, 1, 1, 32'h0000FFFF, 32'h200, 32'hCAFEF00D, 0, 1, 0, 0, "store");
      cyc(0, 0, 1, 0, 0, 32'h200, 0, 0, 1, 2, 32'h1111F00D, "load_after_store");
      idle(1);

      // Reset in the cycle after a fetch grant drops the response
      cyc(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rmr_fetch");
      rst = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk("rmr_rvalid_n1", {62'h0, if_rvalid, ls_rvalid}, 64'h0);
      chk("rmr_rdata_n1", {if_rdata, ls_rdata}, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rmr_ctrl_n2", {58'h0, if_gnt, ls_gnt, mem_en, mem_wr_en, if_rvalid, ls_rvalid}, 64'h0);
      chk("rmr_rdata_n2", {if_rdata, ls_rdata}, 64'h0);
      chk("rmr_owner", 64'(dut.owner), 64'(OWNER_NONE));
      @(posedge clk);
      #1;

      // Back-to-back fetches
      cyc(1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00000013, "b2b_0");
      cyc(1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00100113, "b2b_1");
      cyc(1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 32'h00200193, "b2b_2");
      idle(1);
      chk("scoreboard_drained", 64'(sb.size()), 64'h0);
      idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one arbiter that shares a single-port, synchronous-read unified memory between the core's instruction-fetch port and its load/store port. It sits between `core` and the unified memory. Each cycle it grants at most one request, routes the registered read response back to the port that issued it, and keeps fetch from starving under sustained load/store traffic.

## Interface
Parameters:
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits.
- `MAX_STALL`, 4, number of consecutive denied fetch cycles before fetch is forced to priority. Range 1..15.

Ports:
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_req` input 1: fetch read request. Held with `if_addr` stable until granted.
- `if_addr` input ADDR_W: fetch byte address.
- `if_gnt` output 1: fetch request accepted this cycle (combinational).
- `if_rvalid` output 1: `if_rdata` is valid this cycle.
- `if_rdata` output DATA_W: fetch read data.
- `ls_req` input 1: load/store request. Held until granted.
- `ls_we` input 1: 1 means write, 0 means read.
- `ls_bit_wr_en` input DATA_W: per-bit write enable, used only when `ls_we`=1.
- `ls_addr` input ADDR_W: load/store byte address.
- `ls_wr_data` input DATA_W: write data.
- `ls_gnt` output 1: load/store request accepted this cycle (combinational).
- `ls_rvalid` output 1: `ls_rdata` is valid this cycle (reads only).
- `ls_rdata` output DATA_W: load read data.
- `mem_en` output 1: memory access this cycle.
- `mem_wr_en` output 1: memory write.
- `mem_bit_wr_en` output DATA_W: per-bit write enable.
- `mem_addr` output ADDR_W: memory address.
- `mem_wr_data` output DATA_W: memory write data.
- `mem_rd_data` input DATA_W: memory read data, valid one cycle after a read with `mem_en`=1.

## Operation
Arbitration is combinational and evaluated every cycle:
- Only one port requesting: that port is granted.
- Both ports requesting, `stall_cnt` < MAX_STALL: `ls` is granted and fetch is denied.
- Both ports requesting, `stall_cnt` == MAX_STALL: `if` is granted.
- No request: `mem_en`=0. `mem_wr_en`, `mem_bit_wr_en`, `mem_addr` and `mem_wr_data` are driven to 0.
- Memory command outputs mirror the granted port. Fetch is always a read: `mem_wr_en`=0, `mem_bit_wr_en`=0.

Starvation counter `stall_cnt` (4 bits):
- Increments when `if_req`=1 and `if_gnt`=0.
- Clears to 0 when fetch is granted or `if_req`=0.
- Saturates at MAX_STALL.

Response-owner register `owner`, with states NONE / IF / LS:
- Loads IF on a fetch grant.
- Loads LS on a load (read) grant.
- Loads NONE on a store grant or an idle cycle.
- `if_rvalid` = (`owner`==IF). `ls_rvalid` = (`owner`==LS).
- `if_rdata` and `ls_rdata` both carry `mem_rd_data` when their rvalid is 1, and 0 otherwise.

Throughput and boundary rules:
- Back-to-back grants every cycle are legal. A new grant in cycle N+1 coexists with the response for the cycle-N grant.
- A store followed by a load to the same address in the next cycle returns the new data. The memory is write-first, and the arbiter adds no hazard logic.
- A request dropped before grant is a protocol violation. It is not checked, and the design must not hang.

## Timing
- Grant latency: 0 cycles, same cycle as the request when it wins arbitration.
- Read latency: `*_rvalid` is asserted exactly 1 cycle after the `*_gnt` cycle, for 1 cycle.
- Stores produce no `rvalid`.
- Reset values: `stall_cnt`=0, `owner`=NONE. All outputs are 0 during reset and in the first cycle after it, including `if_rvalid`, `ls_rvalid` and the rdata outputs.
- While `rst`=1, both `gnt` outputs and `mem_en` are forced to 0.
- Reset in the cycle after a grant drops the pending response: no `rvalid` is issued for that read.
- Worst-case fetch wait under continuous `ls` traffic: MAX_STALL denied cycles, then a grant in the next cycle.

## Structure
- Package `mem_arb_pkg` holds:
  - the `owner_e` enum (NONE, IF, LS), 2 bits;
  - the default `ADDR_W`/`DATA_W` localparams;
  - the `stall_cnt` width constant.
- Single module, no sub-modules. Grant logic and the two registers sit in one `always_comb` and one `always_ff`.
- Integration: `mem_arbiter` is instantiated in the top level between `core` and a unified memory with a synchronous read.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x10, memory[0x10]=0x00500093.
  - Required: `if_gnt`=1 in cycle 0.
  - Required: `if_rvalid`=1 and `if_rdata`=0x00500093 in cycle 1, `ls_rvalid`=0.
- Collision: both ports request in the same cycle, `ls` reads 0x100, which holds 0xDEADBEEF.
  - Required: `ls_gnt`=1 and `if_gnt`=0.
  - Required next cycle: `ls_rvalid`=1 with 0xDEADBEEF.
  - Required next cycle: the fetch is granted once `ls_req` drops.
- Starvation, MAX_STALL=4: `ls_req` held high continuously with stores, `if_req` held high.
  - Required: fetch is denied in cycles 0-3 and `if_gnt`=1 in cycle 4.
  - Required: `stall_cnt` returns to 0 and `ls` is granted in cycle 5.
- Store then load: `ls` writes 0xCAFEF00D to 0x200 with `ls_bit_wr_en`=0x0000FFFF over prior data 0x11112222, then reads 0x200.
  - Required: `ls_rdata`=0x1111F00D.
  - Required: no `ls_rvalid` for the store cycle.
- Reset mid-read: fetch granted in cycle N, `rst`=1 in cycle N+1.
  - Required: `if_rvalid`=0 in cycles N+1 and N+2.
  - Required: all outputs are 0 and `owner` is NONE after reset.
- Back-to-back fetches to 0x0, 0x4, 0x8 in consecutive cycles.
  - Required: three consecutive `if_rvalid` pulses, one per cycle, carrying the matching words in order.
